// File: rtl/regfile_gen_pkg.sv
// rtl/regfile_gen_pkg.sv - register map helpers shared by the register file and its bench
package regfile_gen_pkg;

    // PC occupies the top slot, SP the one below it; everything lower is general purpose.
    function automatic int pcIndex(input int nRegs);
        return nRegs - 1;
    endfunction

    function automatic int spIndex(input int nRegs);
        return nRegs - 2;
    endfunction

endpackage

// File: rtl/regfile_gen_counting_register.sv
// rtl/regfile_gen_counting_register.sv - loadable up/down counter used for SP and PC
module regfile_gen_counting_register #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             notReset,
    input  logic             notLoad,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load wins; inc and dec together cancel. Arithmetic wraps with no carry out.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            q <= RESET_VAL;
        end else if (!notLoad) begin
            q <= d;
        end else if (inc && !dec) begin
            q <= q + WIDTH'(1);
        end else if (dec && !inc) begin
            q <= q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/regfile_gen.sv
// rtl/regfile_gen.sv - parametrised register file with tri-state read ports, PC/SP counters and contention flag
module regfile_gen
    import regfile_gen_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               NREGS    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] RESET_SP = '1
) (
    input  logic             clock,
    input  logic             notReset,
    input  logic [WIDTH-1:0] yBus,
    input  logic [NREGS-1:0] notLoad,
    input  logic [NREGS-1:0] notOEA,
    input  logic [NREGS-1:0] notOEB,
    input  logic             pcInc,
    input  logic             spInc,
    input  logic             spDec,
    input  logic             clrFault,
    inout  wire  [WIDTH-1:0] aBus,
    inout  wire  [WIDTH-1:0] bBus,
    output logic             contention
);

    localparam int PC_IDX = pcIndex(NREGS);
    localparam int SP_IDX = spIndex(NREGS);

    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]            dataA;
    logic [WIDTH-1:0]            dataB;
    logic                        enA;
    logic                        enB;
    logic                        multiA;
    logic                        multiB;

    for (genvar g = 0; g < NREGS - 2; g++) begin : gGp
        logic [WIDTH-1:0] q;
        always_ff @(posedge clock or negedge notReset) begin
            if (!notReset) begin
                q <= '0;
            end else if (!notLoad[g]) begin
                q <= yBus;
            end
        end
        assign regs[g] = q;
    end

    regfile_gen_counting_register #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_SP)
    ) uSp (
        .clock    (clock),
        .notReset (notReset),
        .notLoad  (notLoad[SP_IDX]),
        .inc      (spInc),
        .dec      (spDec),
        .d        (yBus),
        .q        (regs[SP_IDX])
    );

    regfile_gen_counting_register #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_PC)
    ) uPc (
        .clock    (clock),
        .notReset (notReset),
        .notLoad  (notLoad[PC_IDX]),
        .inc      (pcInc),
        .dec      (1'b0),
        .d        (yBus),
        .q        (regs[PC_IDX])
    );

    // Scanning downward leaves the lowest enabled index selected, so an illegal
    // multi-enable word still drives exactly one register onto the bus.
    always_comb begin
        dataA = '0;
        dataB = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (!notOEA[i]) dataA = regs[i];
            if (!notOEB[i]) dataB = regs[i];
        end
    end

    assign enA    = ~&notOEA;
    assign enB    = ~&notOEB;
    assign multiA = $countones(~notOEA) > 1;
    assign multiB = $countones(~notOEB) > 1;

    assign aBus = enA ? dataA : 'z;
    assign bBus = enB ? dataB : 'z;

    // New contention outranks clrFault on the same edge.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            contention <= 1'b0;
        end else if (multiA || multiB) begin
            contention <= 1'b1;
        end else if (clrFault) begin
            contention <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_gen.sv
// tb/tb_regfile_gen.sv - directed self-checking bench for regfile_gen at default and narrow parameters
`timescale 1ns/1ps
module tb_regfile_gen;

    logic        clock = 1'b0;
    logic        notReset;
    logic [15:0] yBus;
    logic [7:0]  notLoad, notOEA, notOEB;
    logic        pcInc, spInc, spDec, clrFault;
    wire  [15:0] aBus, bBus;
    logic        contention;

    logic [7:0]  yBus8;
    logic [3:0]  notLoad8, notOEA8, notOEB8;
    logic        pcInc8, spInc8, spDec8, clrFault8;
    wire  [7:0]  aBus8, bBus8;
    logic        contention8;

    int checks = 0;
    int errors = 0;

    // Undriven buses float high, so "high-Z" reads back as all ones.
    for (genvar i = 0; i < 16; i++) begin : gPull
        pullup (aBus[i]);
        pullup (bBus[i]);
    end
    for (genvar i = 0; i < 8; i++) begin : gPull8
        pullup (aBus8[i]);
        pullup (bBus8[i]);
    end

    always #5 clock = ~clock;

    regfile_gen dut (
        .clock(clock), .notReset(notReset), .yBus(yBus), .notLoad(notLoad),
        .notOEA(notOEA), .notOEB(notOEB), .pcInc(pcInc), .spInc(spInc),
        .spDec(spDec), .clrFault(clrFault), .aBus(aBus), .bBus(bBus),
        .contention(contention)
    );

    regfile_gen #(.WIDTH(8), .NREGS(4)) dut8 (
        .clock(clock), .notReset(notReset), .yBus(yBus8), .notLoad(notLoad8),
        .notOEA(notOEA8), .notOEB(notOEB8), .pcInc(pcInc8), .spInc(spInc8),
        .spDec(spDec8), .clrFault(clrFault8), .aBus(aBus8), .bBus(bBus8),
        .contention(contention8)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        yBus = 16'h0000; notLoad = 8'hFF; notOEA = 8'hFF; notOEB = 8'hFF;
        pcInc = 1'b0; spInc = 1'b0; spDec = 1'b0; clrFault = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        notReset = 1'b0;
        notLoad = 8'h00; yBus = 16'h1234; pcInc = 1'b1; spDec = 1'b1;
        tick(); tick();
        idle();
        #1;
        checks++; if (contention !== 1'b0) begin errors++; $display("FAIL reset_contention got %b want 0", contention); end
        checks++; if (aBus !== 16'hFFFF) begin errors++; $display("FAIL reset_a_z got %h want FFFF", aBus); end
        checks++; if (bBus !== 16'hFFFF) begin errors++; $display("FAIL reset_b_z got %h want FFFF", bBus); end
        notOEA = ~8'h80; notOEB = ~8'h40; #1;
        checks++; if (aBus !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", aBus); end
        checks++; if (bBus !== 16'hFFFF) begin errors++; $display("FAIL reset_sp got %h want FFFF", bBus); end
        notOEA = ~8'h01; #1;
        checks++; if (aBus !== 16'h0000) begin errors++; $display("FAIL reset_r0 got %h want 0000", aBus); end
        idle();
        notReset = 1'b1;
        notLoad = ~8'h01; yBus = 16'h1234; tick();
        notLoad = ~8'h01; yBus = 16'h5555; notOEA = ~8'h01;
        #2 notReset = 1'b0;
        #1;
        checks++; if (aBus !== 16'h0000) begin errors++; $display("FAIL async_reset_r0 got %h want 0000", aBus); end
        idle();
        #1 notReset = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        idle();
        notLoad = ~8'h04; yBus = 16'h1234; notOEA = ~8'h04; #1;
        checks++; if (aBus !== 16'h0000) begin errors++; $display("FAIL read_before_write got %h want 0000", aBus); end
        tick();
        checks++; if (aBus !== 16'h1234) begin errors++; $display("FAIL read_after_write got %h want 1234", aBus); end
        idle();
        notLoad = ~8'h40; yBus = 16'h0010; tick();
        idle();
        notOEA = ~8'h04; notOEB = ~8'h40; #1;
        checks++; if (aBus !== 16'h1234) begin errors++; $display("FAIL read_a_r2 got %h want 1234", aBus); end
        checks++; if (bBus !== 16'h0010) begin errors++; $display("FAIL read_b_sp got %h want 0010", bBus); end
        notOEB = ~8'h04; #1;
        checks++; if (bBus !== 16'h1234) begin errors++; $display("FAIL read_b_same got %h want 1234", bBus); end
        notOEA = 8'hFF; notOEB = 8'hFF; #1;
        checks++; if (aBus !== 16'hFFFF || bBus !== 16'hFFFF) begin errors++; $display("FAIL read_both_z got %h %h want FFFF FFFF", aBus, bBus); end
        notLoad = ~8'h03; yBus = 16'hBEEF; tick();
        idle();
        notOEA = ~8'h01; notOEB = ~8'h02; #1;
        checks++; if (aBus !== 16'hBEEF || bBus !== 16'hBEEF) begin errors++; $display("FAIL multi_load got %h %h want BEEF BEEF", aBus, bBus); end
        checks++; if (contention !== 1'b0) begin errors++; $display("FAIL multi_load_no_fault got %b want 0", contention); end
    endtask

    task automatic test_pc();
        idle();
        notLoad = ~8'h80; yBus = 16'hFFFE; tick();
        idle();
        pcInc = 1'b1; notOEA = ~8'h80;
        tick();
        checks++; if (aBus !== 16'hFFFF) begin errors++; $display("FAIL pc_inc1 got %h want FFFF", aBus); end
        tick();
        checks++; if (aBus !== 16'h0000) begin errors++; $display("FAIL pc_wrap got %h want 0000", aBus); end
        tick();
        checks++; if (aBus !== 16'h0001) begin errors++; $display("FAIL pc_inc3 got %h want 0001", aBus); end
        notLoad = ~8'h80; yBus = 16'h0100; tick();
        checks++; if (aBus !== 16'h0100) begin errors++; $display("FAIL pc_load_over_inc got %h want 0100", aBus); end
    endtask

    task automatic test_sp();
        idle();
        notLoad = ~8'h40; yBus = 16'h0000; tick();
        idle();
        notOEB = ~8'h40; spDec = 1'b1; tick();
        checks++; if (bBus !== 16'hFFFF) begin errors++; $display("FAIL sp_dec_wrap got %h want FFFF", bBus); end
        spInc = 1'b1; tick();
        checks++; if (bBus !== 16'hFFFF) begin errors++; $display("FAIL sp_inc_dec_hold got %h want FFFF", bBus); end
        spDec = 1'b0; tick();
        checks++; if (bBus !== 16'h0000) begin errors++; $display("FAIL sp_inc_wrap got %h want 0000", bBus); end
        spInc = 1'b0; spDec = 1'b1; notLoad = ~8'h40; yBus = 16'h8000; tick();
        checks++; if (bBus !== 16'h8000) begin errors++; $display("FAIL sp_load_over_dec got %h want 8000", bBus); end
    endtask

    task automatic test_contention();
        idle();
        notLoad = ~8'h02; yBus = 16'hAAAA; tick();
        notLoad = ~8'h08; yBus = 16'h5555; tick();
        idle();
        notOEA = ~8'h0A; #1;
        checks++; if (aBus !== 16'hAAAA) begin errors++; $display("FAIL cont_lowest_a got %h want AAAA", aBus); end
        checks++; if (contention !== 1'b0) begin errors++; $display("FAIL cont_not_yet got %b want 0", contention); end
        tick();
        checks++; if (contention !== 1'b1) begin errors++; $display("FAIL cont_set got %b want 1", contention); end
        notOEA = 8'hFF; tick();
        checks++; if (contention !== 1'b1) begin errors++; $display("FAIL cont_sticky got %b want 1", contention); end
        clrFault = 1'b1; tick();
        checks++; if (contention !== 1'b0) begin errors++; $display("FAIL cont_clear got %b want 0", contention); end
        notOEB = ~8'h28; #1;
        checks++; if (bBus !== 16'h5555) begin errors++; $display("FAIL cont_lowest_b got %h want 5555", bBus); end
        tick();
        checks++; if (contention !== 1'b1) begin errors++; $display("FAIL cont_over_clear got %b want 1", contention); end
        tick();
        checks++; if (contention !== 1'b1) begin errors++; $display("FAIL cont_persist got %b want 1", contention); end
        notOEB = 8'hFF; tick();
        checks++; if (contention !== 1'b0) begin errors++; $display("FAIL cont_clear2 got %b want 0", contention); end
        idle();
    endtask

    task automatic test_params();
        notOEA8 = ~4'h8; notOEB8 = ~4'h4; #1;
        checks++; if (aBus8 !== 8'h00) begin errors++; $display("FAIL p_reset_pc got %h want 00", aBus8); end
        checks++; if (bBus8 !== 8'hFF) begin errors++; $display("FAIL p_reset_sp got %h want FF", bBus8); end
        notLoad8 = ~4'h8; yBus8 = 8'hFF; tick();
        notLoad8 = 4'hF;
        checks++; if (aBus8 !== 8'hFF) begin errors++; $display("FAIL p_pc_load got %h want FF", aBus8); end
        pcInc8 = 1'b1; spDec8 = 1'b1; tick();
        pcInc8 = 1'b0; spDec8 = 1'b0;
        checks++; if (aBus8 !== 8'h00) begin errors++; $display("FAIL p_pc_wrap got %h want 00", aBus8); end
        checks++; if (bBus8 !== 8'hFE) begin errors++; $display("FAIL p_sp_dec got %h want FE", bBus8); end
        notLoad8 = ~4'h2; yBus8 = 8'h5A; tick();
        notLoad8 = 4'hF;
        notOEA8 = ~4'h2; notOEB8 = 4'hF; #1;
        checks++; if (aBus8 !== 8'h5A || bBus8 !== 8'hFF) begin errors++; $display("FAIL p_gp_read got %h %h want 5A FF", aBus8, bBus8); end
        notOEA8 = 4'b1100; #1;
        checks++; if (aBus8 !== 8'h00) begin errors++; $display("FAIL p_cont_lowest got %h want 00", aBus8); end
        tick();
        checks++; if (contention8 !== 1'b1) begin errors++; $display("FAIL p_cont_set got %b want 1", contention8); end
        notOEA8 = 4'hF; clrFault8 = 1'b1; tick();
        checks++; if (contention8 !== 1'b0) begin errors++; $display("FAIL p_cont_clear got %b want 0", contention8); end
    endtask

    initial begin
        notReset = 1'b0;
        idle();
        yBus8 = 8'h00; notLoad8 = 4'hF; notOEA8 = 4'hF; notOEB8 = 4'hF;
        pcInc8 = 1'b0; spInc8 = 1'b0; spDec8 = 1'b0; clrFault8 = 1'b0;
        #2;
        test_reset();
        test_write_read();
        test_pc();
        test_sp();
        test_contention();
        test_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
